// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory-access pipeline stage.
package mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/mem_wb_reg.sv
// Write-back output register: valid tracks the load strobe every cycle,
// the payload fields only change when a retiring instruction loads them.
module mem_wb_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              rf_we_next,
    input  logic [DATA_W-1:0] data_next,
    input  logic              next_pc_next,
    input  logic              err_next,
    output logic              valid,
    output logic              rf_we,
    output logic [DATA_W-1:0] data,
    output logic              next_pc,
    output logic              err
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            rf_we   <= 1'b0;
            data    <= '0;
            next_pc <= 1'b0;
            err     <= 1'b0;
        end else begin
            valid <= load;
            if (load) begin
                rf_we   <= rf_we_next;
                data    <= data_next;
                next_pc <= next_pc_next;
                err     <= err_next;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results through to write-back and
// runs a req/ack data-memory transaction for loads and stores, with timeout abort.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_VALID,
    input  logic              MEM_DM_WE,
    input  logic              MEM_RF_D_SEL,
    input  logic              MEM_RF_WE,
    input  logic [DATA_W-1:0] MEM_ALU_RES,
    input  logic [DATA_W-1:0] MEM_muxB,
    input  logic [ADDR_W-1:0] MEM_DM_ADDR,
    input  logic              MEM_NEXT_PC,
    output logic              STALL,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              WB_VALID,
    output logic              WB_RF_WE,
    output logic [DATA_W-1:0] WB_DATA,
    output logic              WB_NEXT_PC,
    output logic              WB_ERR
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    count;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W-1:0]   req_alu;
    logic                mem_op;
    logic                timeout_hit;
    logic                stall_raw;
    logic                wb_load;
    logic                wb_rf_we_next;
    logic [DATA_W-1:0]   wb_data_next;
    logic                wb_err_next;

    // Both store and load flags set is handled as a store.
    assign mem_op      = MEM_VALID & (MEM_DM_WE | MEM_RF_D_SEL);
    assign timeout_hit = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT - 1)) && !dm_ack;

    always_comb begin
        state_next    = state;
        stall_raw     = 1'b0;
        wb_load       = 1'b0;
        wb_rf_we_next = MEM_RF_WE;
        wb_data_next  = MEM_ALU_RES;
        wb_err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall_raw  = 1'b1;
                    state_next = ACCESS;
                end else if (MEM_VALID) begin
                    wb_load = 1'b1;
                end
            end
            ACCESS: begin
                if (dm_ack) begin
                    state_next   = IDLE;
                    wb_load      = 1'b1;
                    wb_data_next = req_we ? req_alu : dm_rdata;
                end else if (timeout_hit) begin
                    // Aborted instruction keeps the previous write-back data.
                    state_next    = IDLE;
                    wb_load       = 1'b1;
                    wb_err_next   = 1'b1;
                    wb_rf_we_next = 1'b0;
                    wb_data_next  = WB_DATA;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign STALL = stall_raw & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_alu   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && mem_op) begin
                count     <= '0;
                req_we    <= MEM_DM_WE;
                req_addr  <= MEM_DM_ADDR;
                req_wdata <= MEM_muxB;
                req_alu   <= MEM_ALU_RES;
            end else if (state == ACCESS) begin
                count <= count + 1'b1;
                if (state_next == IDLE) begin
                    req_we <= 1'b0;
                end
            end
        end
    end

    assign dm_req   = (state == ACCESS);
    assign dm_we    = req_we;
    assign dm_addr  = req_addr;
    assign dm_wdata = req_wdata;

    mem_wb_reg #(
        .DATA_W(DATA_W)
    ) u_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (wb_load),
        .rf_we_next   (wb_rf_we_next),
        .data_next    (wb_data_next),
        .next_pc_next (MEM_NEXT_PC),
        .err_next     (wb_err_next),
        .valid        (WB_VALID),
        .rf_we        (WB_RF_WE),
        .data         (WB_DATA),
        .next_pc      (WB_NEXT_PC),
        .err          (WB_ERR)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: retirements are scored against a queue of
// expected write-back entries, handshake/stall timing is checked inline.
module tb_mem_stage;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    typedef struct {
        logic              rf_we;
        logic [DATA_W-1:0] data;
        logic              next_pc;
        logic              err;
        logic              chk_data;
    } wb_exp_t;

    logic              clk;
    logic              rst;
    logic              mem_valid;
    logic              mem_dm_we;
    logic              mem_rf_d_sel;
    logic              mem_rf_we;
    logic [DATA_W-1:0] mem_alu_res;
    logic [DATA_W-1:0] mem_muxb;
    logic [ADDR_W-1:0] mem_dm_addr;
    logic              mem_next_pc;
    logic              stall;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;
    logic              wb_valid;
    logic              wb_rf_we;
    logic [DATA_W-1:0] wb_data;
    logic              wb_next_pc;
    logic              wb_err;

    wb_exp_t sb_queue[$];
    int      tests_run = 0;
    int      tests_failed = 0;

    mem_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MEM_VALID   (mem_valid),
        .MEM_DM_WE   (mem_dm_we),
        .MEM_RF_D_SEL(mem_rf_d_sel),
        .MEM_RF_WE   (mem_rf_we),
        .MEM_ALU_RES (mem_alu_res),
        .MEM_muxB    (mem_muxb),
        .MEM_DM_ADDR (mem_dm_addr),
        .MEM_NEXT_PC (mem_next_pc),
        .STALL       (stall),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_ack      (dm_ack),
        .dm_rdata    (dm_rdata),
        .WB_VALID    (wb_valid),
        .WB_RF_WE    (wb_rf_we),
        .WB_DATA     (wb_data),
        .WB_NEXT_PC  (wb_next_pc),
        .WB_ERR      (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic we, input logic d_sel,
                                 input logic rf_we, input logic [DATA_W-1:0] alu,
                                 input logic [DATA_W-1:0] muxb,
                                 input logic [ADDR_W-1:0] addr, input logic next_pc);
        mem_valid    = valid;
        mem_dm_we    = we;
        mem_rf_d_sel = d_sel;
        mem_rf_we    = rf_we;
        mem_alu_res  = alu;
        mem_muxb     = muxb;
        mem_dm_addr  = addr;
        mem_next_pc  = next_pc;
    endtask

    // Scoreboard: every retirement must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (sb_queue.size() == 0) begin
                checkOutput("sb_unexpected_wb", 32'd1, 32'd0);
            end else begin
                wb_exp_t e;
                e = sb_queue.pop_front();
                checkOutput("sb_rf_we", {31'd0, wb_rf_we}, {31'd0, e.rf_we});
                checkOutput("sb_next_pc", {31'd0, wb_next_pc}, {31'd0, e.next_pc});
                checkOutput("sb_err", {31'd0, wb_err}, {31'd0, e.err});
                if (e.chk_data) checkOutput("sb_data", wb_data, e.data);
            end
        end
    end

    // Drives one load/store (ack_cycle 0 = never ack) and measures req/stall length.
    task automatic runMemOp(input string tag, input logic is_store, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] alu,
                            input logic rf_we, input logic next_pc, input int ack_cycle,
                            input logic [DATA_W-1:0] rdata, input int exp_cycles);
        int      req_cnt;
        int      stall_cnt;
        wb_exp_t e;
        req_cnt   = 0;
        stall_cnt = 0;
        e.next_pc = next_pc;
        if (ack_cycle == 0) begin
            e.rf_we = 1'b0; e.data = '0; e.err = 1'b1; e.chk_data = 1'b0;
        end else begin
            e.rf_we = rf_we; e.data = is_store ? alu : rdata; e.err = 1'b0; e.chk_data = 1'b1;
        end
        applyStimulus(1'b1, is_store, 1'b1, rf_we, alu, wdata, addr, next_pc);
        sb_queue.push_back(e);
        #1;
        if (stall) stall_cnt++;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            if (!dm_req) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
                dm_ack = 1'b0;
                break;
            end
            req_cnt++;
            checkOutput({tag, "_dm_we"}, {31'd0, dm_we}, {31'd0, is_store});
            checkOutput({tag, "_dm_addr"}, {16'd0, dm_addr}, {16'd0, addr});
            if (is_store) checkOutput({tag, "_dm_wdata"}, dm_wdata, wdata);
            dm_ack   = (cyc == ack_cycle);
            dm_rdata = (cyc == ack_cycle) ? rdata : 32'h5555_5555;
            #1;
            if (stall) stall_cnt++;
        end
        checkOutput({tag, "_req_cycles"}, req_cnt, exp_cycles);
        checkOutput({tag, "_stall_cycles"}, stall_cnt, exp_cycles);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        dm_ack   = 1'b0;
        dm_rdata = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        #2;
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_dm_req", {31'd0, dm_req}, 32'd0);
        checkOutput("rst_dm_we", {31'd0, dm_we}, 32'd0);
        checkOutput("rst_dm_addr", {16'd0, dm_addr}, 32'd0);
        checkOutput("rst_dm_wdata", dm_wdata, 32'd0);
        checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("rst_wb_rf_we", {31'd0, wb_rf_we}, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_wb_next_pc", {31'd0, wb_next_pc}, 32'd0);
        checkOutput("rst_wb_err", {31'd0, wb_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ALU pass-through, then an idle cycle that must hold the payload.
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h0, 16'h0, 1'b1);
        sb_queue.push_back('{1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b1});
        #1;
        checkOutput("alu_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, '0, '0, 1'b0);
        checkOutput("alu_stall_after", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        checkOutput("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("idle_wb_data_hold", wb_data, 32'h1234_5678);
        checkOutput("idle_wb_rf_we_hold", {31'd0, wb_rf_we}, 32'd1);

        runMemOp("load", 1'b0, 16'h0040, 32'h0, 32'h0000_0040, 1'b1, 1'b0, 3, 32'hDEAD_BEEF, 3);
        @(posedge clk); #1;
        runMemOp("store", 1'b1, 16'h0010, 32'hCAFE_F00D, 32'h0000_0010, 1'b0, 1'b1, 1,
                 32'h0, 1);
        @(posedge clk); #1;
        runMemOp("tmo", 1'b0, 16'h0020, 32'h0, 32'h0000_0020, 1'b1, 1'b1, 0, 32'h0, TIMEOUT);

        // Late ack after the abort must be ignored.
        @(posedge clk); #1;
        dm_ack   = 1'b1;
        dm_rdata = 32'hBAD0_BAD0;
        #1;
        checkOutput("late_ack_dm_req", {31'd0, dm_req}, 32'd0);
        checkOutput("late_ack_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        checkOutput("late_ack_wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("late_ack_dm_req2", {31'd0, dm_req}, 32'd0);

        // Reset in the second request cycle of a load discards it.
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0080, '0, 16'h0080, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rstmid_req_before", {31'd0, dm_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstmid_dm_req", {31'd0, dm_req}, 32'd0);
        checkOutput("rstmid_stall", {31'd0, stall}, 32'd0);
        checkOutput("rstmid_dm_addr", {16'd0, dm_addr}, 32'd0);
        checkOutput("rstmid_wb_valid", {31'd0, wb_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rstmid_req_after", {31'd0, dm_req}, 32'd0);
        checkOutput("rstmid_wb_after", {31'd0, wb_valid}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0BAD_CAFE, '0, '0, 1'b1);
        sb_queue.push_back('{1'b1, 32'h0BAD_CAFE, 1'b1, 1'b0, 1'b1});
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        checkOutput("post_rst_wb_valid", {31'd0, wb_valid}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drained", sb_queue.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined processor: sits directly downstream of the EX/MEM pipeline register and upstream of the register-file write-back. Non-memory instructions pass through to the write-back register. For loads and stores it runs a req/ack transaction on the data-memory port. While the access is outstanding it stalls the upstream pipeline, and it aborts with an error flag if memory does not answer within a bounded number of cycles.

## Interface
Parameters:
- ADDR_W, 16, data-memory address width
- DATA_W, 32, datapath width
- TIMEOUT, 255, max req cycles before abort; 0 disables timeout

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- MEM_VALID  in  1  instruction present in MEM stage
- MEM_DM_WE  in  1  store when 1
- MEM_RF_D_SEL  in  1  load when 1 (write-back data from memory); 0 = ALU result
- MEM_RF_WE  in  1  instruction writes register file
- MEM_ALU_RES  in  DATA_W  ALU result
- MEM_muxB  in  DATA_W  store data
- MEM_DM_ADDR  in  ADDR_W  memory address
- MEM_NEXT_PC  in  1  next-PC flag, passed through
- STALL  out  1  hold EX/MEM register and all upstream stages
- dm_req  out  1  memory request
- dm_we  out  1  request is a write
- dm_addr  out  ADDR_W  request address
- dm_wdata  out  DATA_W  write data
- dm_ack  in  1  memory completion, sampled on clk
- dm_rdata  in  DATA_W  read data, valid with dm_ack
- WB_VALID  out  1  write-back slot holds a retired instruction
- WB_RF_WE  out  1  register-file write enable
- WB_DATA  out  DATA_W  write-back data
- WB_NEXT_PC  out  1  registered MEM_NEXT_PC
- WB_ERR  out  1  instruction aborted by timeout

## Operation
- Memory op = MEM_VALID & (MEM_DM_WE | MEM_RF_D_SEL). MEM_DM_WE and MEM_RF_D_SEL both 1 is treated as a store.
- FSM states: IDLE, ACCESS.
- IDLE, non-memory op: WB_DATA <= MEM_ALU_RES, WB_RF_WE <= MEM_RF_WE, WB_VALID <= 1, WB_ERR <= 0. STALL = 0.
- IDLE, no valid input: WB_VALID <= 0. WB_DATA and WB_RF_WE hold their values.
- IDLE, memory op: STALL = 1. Latch address, write data and we into request registers; reset the counter to 0; go to ACCESS. WB_VALID <= 0.
- ACCESS: dm_req = 1 and the request registers drive dm_*. The request stays stable until it ends. The counter increments each cycle.
- ACCESS with dm_ack = 1: STALL = 0; go to IDLE.
  - Load: WB_DATA <= dm_rdata.
  - Store: WB_DATA <= held ALU result.
  - WB_VALID <= 1, WB_RF_WE <= MEM_RF_WE.
- Timeout: in ACCESS, counter == TIMEOUT-1 with dm_ack = 0 triggers an abort (only when TIMEOUT != 0).
  - STALL = 0; go to IDLE.
  - WB_VALID <= 1, WB_ERR <= 1, WB_RF_WE <= 0.
- Otherwise in ACCESS: STALL = 1, WB_VALID <= 0.
- dm_ack while in IDLE, including a late ack after an abort, is ignored.
- WB_NEXT_PC is loaded together with every WB_VALID <= 1.

## Timing
- Reset (async): state IDLE, dm_req 0, dm_we 0, dm_addr 0, dm_wdata 0, STALL 0, WB_VALID 0, WB_RF_WE 0, WB_DATA 0, WB_NEXT_PC 0, WB_ERR 0, counter 0.
- STALL is combinational from state, inputs and dm_ack. All other outputs are registered.
- Non-memory op latency: 1 cycle, input at cycle t gives WB at t+1.
- Memory op: input at t, dm_req high from t+1. If ack is sampled in req cycle k (k ≥ 1), WB is valid at t+k+1 and STALL is high for k cycles.
- Timeout: dm_req is high for exactly TIMEOUT cycles; WB_ERR appears the cycle after the last req cycle.
- Reset mid-ACCESS: dm_req drops immediately and asynchronously; the transaction is discarded with no WB.

## Structure
- Package mem_pkg: state enum (IDLE, ACCESS), default ADDR_W, DATA_W, TIMEOUT constants.
- One natural sub-module, mem_wb_reg: the write-back output register with load enable and async reset. FSM, counter and request registers live in mem_stage.

## Test plan
- Reset asserted mid-cycle -> all outputs 0 immediately, STALL 0.
- Non-memory op, MEM_ALU_RES=0x12345678, MEM_RF_WE=1 -> next cycle WB_VALID=1, WB_DATA=0x12345678, STALL never high.
- Load at addr 0x0040, ack in 3rd req cycle with dm_rdata=0xDEADBEEF -> STALL high 3 cycles, dm_req high 3 cycles, dm_we=0, then WB_DATA=0xDEADBEEF, WB_RF_WE=1.
- Store to 0x0010 of 0xCAFEF00D, ack in 1st req cycle -> dm_we=1, dm_wdata=0xCAFEF00D for 1 cycle, STALL 1 cycle, WB_RF_WE=0.
- TIMEOUT=4, load with no ack -> dm_req high exactly 4 cycles, then WB_VALID=1, WB_ERR=1, WB_RF_WE=0. A late ack 2 cycles later has no effect.
- rst pulsed during 2nd req cycle of a load -> dm_req falls asynchronously, no WB_VALID. A following ALU op retires normally 1 cycle later.
